async_fifo_flags: RTL and testbench

ASYNC_FIFO_FLAGS -- requirements
Module: async_fifo_flags

---
 rtl/async_fifo_pkg.sv | 24 ++
 rtl/gray_ptr_sync.sv | 29 ++
 rtl/async_fifo_flags.sv | 173 +++++++++++++++++
 tb/tb_async_fifo_flags.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared constants and Gray-code helpers for async_fifo_flags
package async_fifo_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int PTR_W_MAX       = 32;

  typedef logic [PTR_W_MAX-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic ptr_t gray2bin(input ptr_t gray);
    ptr_t bin;
    bin = gray;
    for (int i = 1; i < PTR_W_MAX; i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// rtl/gray_ptr_sync.sv - multi-flop synchroniser for a Gray-coded pointer
module gray_ptr_sync #(
  parameter int WIDTH  = 7,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] gray_out
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [STAGES-1:0][WIDTH-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], gray_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign gray_out = sync_q[STAGES-1];

endmodule

// File: rtl/async_fifo_flags.sv
// rtl/async_fifo_flags.sv - dual-clock FIFO with Gray-pointer crossing and occupancy flags
module async_fifo_flags
  import async_fifo_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 64,
  parameter int SYNC_STAGES = 2,
  parameter int AF_LEVEL    = DEPTH - 4,
  parameter int AE_LEVEL    = 4,
  parameter int FWFT        = 0,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic              wclk,
  input  logic              rclk,
  input  logic              rst_n,
  input  logic              winc,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              wclr_err,
  output logic              wfull,
  output logic              walmost_full,
  output logic              woverflow,
  output logic [ADDR_W:0]   wlevel,
  input  logic              rinc,
  input  logic              rclr_err,
  output logic [WIDTH-1:0]  rdata,
  output logic              rempty,
  output logic              ralmost_empty,
  output logic              runderflow,
  output logic [ADDR_W:0]   rlevel
);

  localparam int PTR_W  = ADDR_W + 1;
  localparam int SYNC_N = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
                          (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX : SYNC_STAGES;

  // Per-domain reset: asserts with rst_n, releases on the domain's own clock.
  logic [1:0] wrst_q, wrst_d, rrst_q, rrst_d;
  logic       wrst_n, rrst_n;

  always_comb begin
    wrst_d = {wrst_q[0], 1'b1};
    rrst_d = {rrst_q[0], 1'b1};
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) wrst_q <= 2'b00;
    else        wrst_q <= wrst_d;
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) rrst_q <= 2'b00;
    else        rrst_q <= rrst_d;
  end

  assign wrst_n = wrst_q[1];
  assign rrst_n = rrst_q[1];

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wbin_q, wbin_d, wgray_q, wgray_d, wlevel_q, wlevel_d;
  logic [PTR_W-1:0] rgray_sync, rbin_sync;
  logic             wfull_q, wfull_d, waf_q, waf_d, wovf_q, wovf_d, w_accept;

  logic [PTR_W-1:0] rbin_q, rbin_d, rgray_q, rgray_d, rlevel_q, rlevel_d;
  logic [PTR_W-1:0] wgray_sync, wbin_sync;
  logic             rempty_q, rempty_d, rae_q, rae_d, runf_q, runf_d, r_accept;

  gray_ptr_sync #(.WIDTH(PTR_W), .STAGES(SYNC_N)) u_rptr_to_w (
    .clk      (wclk),
    .rst_n    (wrst_n),
    .gray_in  (rgray_q),
    .gray_out (rgray_sync)
  );

  gray_ptr_sync #(.WIDTH(PTR_W), .STAGES(SYNC_N)) u_wptr_to_r (
    .clk      (rclk),
    .rst_n    (rrst_n),
    .gray_in  (wgray_q),
    .gray_out (wgray_sync)
  );

  // Write side: full compares against the read pointer with wrap and next-MSB flipped.
  always_comb begin
    w_accept  = winc && !wfull_q;
    wbin_d    = wbin_q + PTR_W'(w_accept);
    wgray_d   = PTR_W'(bin2gray(ptr_t'(wbin_d)));
    rbin_sync = PTR_W'(gray2bin(ptr_t'(rgray_sync)));
    wfull_d   = (wgray_d == {~rgray_sync[PTR_W-1 -: 2], rgray_sync[PTR_W-3:0]});
    wlevel_d  = wbin_d - rbin_sync;
    waf_d     = (wlevel_d >= PTR_W'(AF_LEVEL));
    wovf_d    = (winc && wfull_q) ? 1'b1 : (wclr_err ? 1'b0 : wovf_q);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      waf_q    <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      waf_q    <= waf_d;
      wovf_q   <= wovf_d;
    end
  end

  always_ff @(posedge wclk) begin
    if (w_accept) mem[wbin_q[ADDR_W-1:0]] <= wdata;
  end

  always_comb begin
    r_accept  = rinc && !rempty_q;
    rbin_d    = rbin_q + PTR_W'(r_accept);
    rgray_d   = PTR_W'(bin2gray(ptr_t'(rbin_d)));
    wbin_sync = PTR_W'(gray2bin(ptr_t'(wgray_sync)));
    rempty_d  = (rgray_d == wgray_sync);
    rlevel_d  = wbin_sync - rbin_d;
    rae_d     = (rlevel_d <= PTR_W'(AE_LEVEL));
    runf_d    = (rinc && rempty_q) ? 1'b1 : (rclr_err ? 1'b0 : runf_q);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q   <= '0;
      rgray_q  <= '0;
      rlevel_q <= '0;
      rempty_q <= 1'b1;
      rae_q    <= 1'b1;
      runf_q   <= 1'b0;
    end else begin
      rbin_q   <= rbin_d;
      rgray_q  <= rgray_d;
      rlevel_q <= rlevel_d;
      rempty_q <= rempty_d;
      rae_q    <= rae_d;
      runf_q   <= runf_d;
    end
  end

  logic [WIDTH-1:0] head_word;
  assign head_word = mem[rbin_q[ADDR_W-1:0]];

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata = rempty_q ? '0 : head_word;
    end else begin : g_reg
      logic [WIDTH-1:0] rdata_q, rdata_d;
      always_comb begin
        rdata_d = r_accept ? head_word : rdata_q;
      end
      always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) rdata_q <= '0;
        else         rdata_q <= rdata_d;
      end
      assign rdata = rdata_q;
    end
  endgenerate

  assign wfull         = wfull_q;
  assign walmost_full  = waf_q;
  assign woverflow     = wovf_q;
  assign wlevel        = wlevel_q;
  assign rempty        = rempty_q;
  assign ralmost_empty = rae_q;
  assign runderflow    = runf_q;
  assign rlevel        = rlevel_q;

endmodule

// File: tb/tb_async_fifo_flags.sv
// tb/tb_async_fifo_flags.sv - scoreboard bench for async_fifo_flags at DEPTH=16
module tb_async_fifo_flags;

  localparam int AW = 4;

  logic        wclk = 1'b0, rclk = 1'b0, rst_n = 1'b0;
  logic        winc = 1'b0, wclr_err = 1'b0, rinc = 1'b0, rclr_err = 1'b0;
  logic [31:0] wdata = '0;
  logic        wfull, walmost_full, woverflow, rempty, ralmost_empty, runderflow;
  logic [AW:0] wlevel, rlevel;
  logic [31:0] rdata;

  logic        winc_f = 1'b0, rinc_f = 1'b0;
  logic [31:0] wdata_f = '0;
  logic        wfull_f, waf_f, wovf_f, rempty_f, rae_f, runf_f;
  logic [AW:0] wlevel_f, rlevel_f;
  logic [31:0] rdata_f;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  bit          wr_done = 1'b0;

  async_fifo_flags #(.WIDTH(32), .DEPTH(16), .SYNC_STAGES(2), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(0)) u_dut (
    .wclk(wclk), .rclk(rclk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .wclr_err(wclr_err),
    .wfull(wfull), .walmost_full(walmost_full), .woverflow(woverflow), .wlevel(wlevel),
    .rinc(rinc), .rclr_err(rclr_err), .rdata(rdata), .rempty(rempty),
    .ralmost_empty(ralmost_empty), .runderflow(runderflow), .rlevel(rlevel)
  );

  async_fifo_flags #(.WIDTH(32), .DEPTH(16), .SYNC_STAGES(2), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1)) u_dut_fwft (
    .wclk(wclk), .rclk(rclk), .rst_n(rst_n), .winc(winc_f), .wdata(wdata_f), .wclr_err(1'b0),
    .wfull(wfull_f), .walmost_full(waf_f), .woverflow(wovf_f), .wlevel(wlevel_f),
    .rinc(rinc_f), .rclr_err(1'b0), .rdata(rdata_f), .rempty(rempty_f),
    .ralmost_empty(rae_f), .runderflow(runf_f), .rlevel(rlevel_f)
  );

  // 100 : 270 period ratio; the 1-unit offset keeps the two clocks' edges apart.
  always #50 wclk = ~wclk;
  initial begin
    #1;
    forever #135 rclk = ~rclk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] d, input bit push);
    @(negedge wclk);
    winc  = 1'b1;
    wdata = d;
    if (push) exp_q.push_back(d);
    @(negedge wclk);
    winc = 1'b0;
  endtask

  // Scoreboard monitor: a pop accepted on an rclk edge must show its word just after it.
  initial begin : monitor
    logic        acc;
    logic [31:0] e;
    forever begin
      @(posedge rclk);
      acc = rinc && !rempty;
      #1;
      if (acc) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_unexpected: got 0x%08h expected no read", rdata);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", rdata, e);
        end
      end
    end
  end

  initial begin : main
    int cnt;
    repeat (3) @(negedge wclk);
    rst_n = 1'b1;
    repeat (4) @(negedge rclk);

    chk("rst_wfull",  32'(wfull), 0);
    chk("rst_waf",    32'(walmost_full), 0);
    chk("rst_wlevel", 32'(wlevel), 0);
    chk("rst_wovf",   32'(woverflow), 0);
    chk("rst_rempty", 32'(rempty), 1);
    chk("rst_rae",    32'(ralmost_empty), 1);
    chk("rst_rlevel", 32'(rlevel), 0);
    chk("rst_runf",   32'(runderflow), 0);
    chk("rst_rdata",  rdata, 0);
    chk("rst_rdata_fwft", rdata_f, 0);

    @(negedge wclk);
    winc_f = 1'b1; wdata_f = 32'hA5A5A5A5;
    @(negedge wclk);
    winc_f = 1'b0;
    cnt = 0;
    while (rempty_f && cnt < 3) begin
      @(posedge rclk); #1; cnt++;
    end
    chk("fwft_rempty", 32'(rempty_f), 0);
    chk("fwft_rdata", rdata_f, 32'hA5A5A5A5);
    @(negedge rclk); rinc_f = 1'b1;
    @(negedge rclk); rinc_f = 1'b0;
    chk("fwft_pop_empty", 32'(rempty_f), 1);
    chk("fwft_pop_rdata", rdata_f, 0);

    wr(32'h0, 1'b1);
    cnt = 0;
    while (rempty && cnt < 3) begin
      @(posedge rclk); #1; cnt++;
    end
    chk("first_word_latency", 32'(rempty), 0);
    for (int i = 1; i < 16; i++) begin
      wr(32'(i), 1'b1);
      if (i == 10) chk("af_below", 32'(walmost_full), 0);
      if (i == 11) begin
        chk("af_level12", 32'(wlevel), 12);
        chk("af_set", 32'(walmost_full), 1);
      end
      if (i == 14) chk("not_full_15", 32'(wfull), 0);
    end
    chk("full_16", 32'(wfull), 1);
    chk("wlevel_16", 32'(wlevel), 16);
    chk("no_ovf_yet", 32'(woverflow), 0);

    wr(32'hBAD0BAD0, 1'b0);
    chk("ovf_set", 32'(woverflow), 1);
    chk("ovf_wlevel", 32'(wlevel), 16);
    @(negedge wclk); winc = 1'b1; wclr_err = 1'b1;
    @(negedge wclk); winc = 1'b0; wclr_err = 1'b0;
    chk("ovf_set_wins", 32'(woverflow), 1);
    @(negedge wclk); wclr_err = 1'b1;
    @(negedge wclk); wclr_err = 1'b0;
    chk("ovf_clear", 32'(woverflow), 0);

    repeat (6) @(negedge rclk);
    chk("rlevel_16", 32'(rlevel), 16);
    chk("rae_full", 32'(ralmost_empty), 0);

    rinc = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge rclk);
      if (k == 11) chk("ae_above", 32'(ralmost_empty), 0);
      if (k == 12) begin
        chk("ae_rlevel4", 32'(rlevel), 4);
        chk("ae_set", 32'(ralmost_empty), 1);
      end
    end
    rinc = 1'b0;
    chk("drain_empty", 32'(rempty), 1);
    chk("drain_sb_empty", 32'(exp_q.size()), 0);
    repeat (6) @(negedge wclk);
    chk("wfull_release", 32'(wfull), 0);
    chk("wlevel_drained", 32'(wlevel), 0);

    @(negedge rclk); rinc = 1'b1;
    @(negedge rclk); rinc = 1'b0;
    chk("unf_set", 32'(runderflow), 1);
    chk("unf_rdata_held", rdata, 32'hF);
    @(negedge rclk); rinc = 1'b1; rclr_err = 1'b1;
    @(negedge rclk); rinc = 1'b0; rclr_err = 1'b0;
    chk("unf_set_wins", 32'(runderflow), 1);
    @(negedge rclk); rclr_err = 1'b1;
    @(negedge rclk); rclr_err = 1'b0;
    chk("unf_clear", 32'(runderflow), 0);
    @(negedge rclk); rinc = 1'b1;
    @(negedge rclk); rinc = 1'b0;
    chk("unf_reset_pre", 32'(runderflow), 1);

    for (int i = 0; i < 8; i++) wr(32'h100 + 32'(i), 1'b0);
    repeat (6) @(negedge rclk);
    chk("pre_reset_rlevel", 32'(rlevel), 8);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rempty", 32'(rempty), 1);
    chk("mid_rst_wlevel", 32'(wlevel), 0);
    chk("mid_rst_rlevel", 32'(rlevel), 0);
    chk("mid_rst_runf",   32'(runderflow), 0);
    chk("mid_rst_rdata",  rdata, 0);
    repeat (3) @(negedge wclk);
    rst_n = 1'b1;
    repeat (4) @(negedge rclk);
    wr(32'hDEADBEEF, 1'b1);
    repeat (5) @(negedge rclk);
    chk("post_rst_rlevel", 32'(rlevel), 1);
    rinc = 1'b1;
    @(negedge rclk); rinc = 1'b0;
    chk("post_rst_sb_empty", 32'(exp_q.size()), 0);
    chk("post_rst_rempty", 32'(rempty), 1);

    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          @(negedge wclk);
          n_checks++;
          if (wlevel > 5'd16) begin
            n_fail++;
            $display("FAIL rand_wlevel: got %0d expected at most 16", wlevel);
          end
          winc = ($urandom_range(0, 1) == 1) && !wfull;
          if (winc) begin
            wdata = $urandom;
            exp_q.push_back(wdata);
          end
        end
        @(negedge wclk);
        winc = 1'b0;
        wr_done = 1'b1;
      end
      begin
        int budget;
        budget = 0;
        while (!(wr_done && exp_q.size() == 0) && budget < 20000) begin
          @(negedge rclk);
          rinc = ($urandom_range(0, 3) != 0) && !rempty;
          budget++;
        end
        rinc = 1'b0;
      end
    join
    repeat (6) @(negedge wclk);
    chk("rand_sb_empty", 32'(exp_q.size()), 0);
    chk("rand_no_ovf", 32'(woverflow), 0);
    chk("rand_no_unf", 32'(runderflow), 0);
    chk("rand_rempty", 32'(rempty), 1);
    chk("rand_wlevel", 32'(wlevel), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
